// File: rtl/ann_layer_sequencer_if.sv
// Host/engine-facing signal bundle for ann_layer_sequencer.
// master = sequencer side, slave = host plus layer engines.
interface ann_layer_sequencer_if #(
  parameter int unsigned N_LAYERS = 3,
  parameter int unsigned CNT_W    = 10
);
  logic                start;
  logic [N_LAYERS-1:0] layer_ready;
  logic                load_data;
  logic [N_LAYERS-1:0] layer_start;
  logic                received;
  logic                done;
  logic                busy;
  logic [CNT_W-1:0]    sample_idx;
  logic                error;

  modport master (
    input  start, layer_ready,
    output load_data, layer_start, received, done, busy, sample_idx, error
  );

  modport slave (
    output start, layer_ready,
    input  load_data, layer_start, received, done, busy, sample_idx, error
  );
endinterface

// File: rtl/ann_layer_sequencer.sv
// Streams N_SAMPLES vectors through N_LAYERS engines, one layer at a time.
// Optional WAIT timeout with sticky error is enabled by defining ANN_SEQ_TIMEOUT_EN.
module ann_layer_sequencer #(
  parameter int unsigned N_SAMPLES   = 750,
  parameter int unsigned N_LAYERS    = 3,
  parameter int unsigned CNT_W       = $clog2(N_SAMPLES + 1),
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ann_layer_sequencer_if.master bus
);
  localparam int unsigned LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam logic [LW-1:0]    LAST_L = LW'(N_LAYERS - 1);
  localparam logic [CNT_W-1:0] LAST_S = CNT_W'(N_SAMPLES - 1);

  if (N_SAMPLES < 1 || N_LAYERS < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("ann_layer_sequencer: N_SAMPLES, N_LAYERS and TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RECV, DONE} state_t;

  state_t           state, state_nx;
  logic [LW-1:0]    layer, layer_nx;
  logic [CNT_W-1:0] idx, idx_nx;

`ifdef ANN_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] wcnt, wcnt_nx;
  logic          err, err_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      layer <= '0;
      idx   <= '0;
`ifdef ANN_SEQ_TIMEOUT_EN
      wcnt  <= '0;
      err   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      layer <= layer_nx;
      idx   <= idx_nx;
`ifdef ANN_SEQ_TIMEOUT_EN
      wcnt  <= wcnt_nx;
      err   <= err_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    layer_nx = layer;
    idx_nx   = idx;
`ifdef ANN_SEQ_TIMEOUT_EN
    wcnt_nx  = wcnt;
    err_nx   = err;
`endif
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = LOAD;
          idx_nx   = '0;
          layer_nx = '0;
`ifdef ANN_SEQ_TIMEOUT_EN
          err_nx   = 1'b0;
`endif
        end
      end
      LOAD: begin
        state_nx = START;
        layer_nx = '0;
      end
      START: begin
        state_nx = WAIT;
`ifdef ANN_SEQ_TIMEOUT_EN
        wcnt_nx  = '0;
`endif
      end
      WAIT: begin
        // Only the current layer's ready bit is ever looked at.
        if (bus.layer_ready[layer]) begin
          if (layer == LAST_L) begin
            state_nx = RECV;
          end else begin
            layer_nx = layer + 1'b1;
            state_nx = START;
          end
        end
`ifdef ANN_SEQ_TIMEOUT_EN
        else if (wcnt == T_LAST) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          wcnt_nx  = wcnt + 1'b1;
        end
`endif
      end
      RECV: begin
        if (idx == LAST_S) begin
          state_nx = DONE;
        end else begin
          idx_nx   = idx + 1'b1;
          state_nx = LOAD;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register, so each pulse lasts one state visit.
  always_comb begin
    bus.layer_start = '0;
    if (state == START) bus.layer_start[layer] = 1'b1;
  end

  assign bus.load_data  = (state == LOAD);
  assign bus.received   = (state == RECV);
  assign bus.done       = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.sample_idx = idx;

`ifdef ANN_SEQ_TIMEOUT_EN
  assign bus.error = err;
`else
  assign bus.error = 1'b0;
`endif
endmodule
